// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Program loader and run supervisor for the 16-bit CPU. It accepts instruction
// words on a valid/ready stream and writes them into instruction memory from
// address 0 upward, holding the CPU in reset while it does so. It then releases
// the CPU and supervises execution until the CPU reports `halted` or a cycle
// budget runs out.
//
// Parameters
//   ADDR_W          instruction memory address width (depth = 2**ADDR_W words)
//   TIMEOUT_CYCLES  maximum number of RUN cycles before a timeout is declared
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   ld_valid     in   loader word valid
//   ld_data      in   instruction word [15:0]
//   ld_last      in   final word of the program (qualified by ld_valid)
//   ld_ready     out  loader can accept a word (LOAD only)
//   start_load   in   begin a new load from DONE / TIMEOUT / ERR
//   halted       in   CPU has executed HALT
//   imem_we      out  instruction memory write enable (registered)
//   imem_waddr   out  write address [ADDR_W-1:0] (registered)
//   imem_wdata   out  write data [15:0] (registered)
//   cpu_reset    out  CPU reset, high in every state except RUN
//   run_done     out  CPU halted normally (level, DONE)
//   run_timeout  out  cycle budget exhausted (level, TIMEOUT)
//   load_err     out  program overflowed memory (level, ERR)
//   word_count   out  words written in the current load [ADDR_W:0]
//   run_cycles   out  RUN cycles elapsed, saturating at 0xFFFF [15:0]
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [15:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              start_load,
    input  logic              halted,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              run_done,
    output logic              run_timeout,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       run_cycles
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_DRAIN,
        S_RUN,
        S_DONE,
        S_TIMEOUT,
        S_ERR
    } state_t;

    // word_count value just before the handshake that fills the top address.
    localparam logic [ADDR_W:0] LAST_ADDR     = {1'b0, {ADDR_W{1'b1}}};
    // The timeout is taken on the RUN cycle whose increment makes run_cycles
    // equal TIMEOUT_CYCLES, so the flag and the final count appear together.
    localparam logic [16:0]     TIMEOUT_M1    = 17'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_nx;
    logic   handshake;
    logic   timeout_hit;
    logic   terminal;

    assign handshake   = ld_valid && (state == S_LOAD);
    assign timeout_hit = ({1'b0, run_cycles} == TIMEOUT_M1);
    assign terminal    = (state == S_DONE) || (state == S_TIMEOUT) || (state == S_ERR);

    // Moore outputs decoded straight from the state register.
    assign ld_ready    = (state == S_LOAD);
    assign cpu_reset   = (state != S_RUN);
    assign run_done    = (state == S_DONE);
    assign run_timeout = (state == S_TIMEOUT);
    assign load_err    = (state == S_ERR);

    // NOTE: state_nx is given a default before the case so every path assigns
    // it; without that a missing branch would infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD: begin
                if (handshake) begin
                    if (ld_last) begin
                        state_nx = S_DRAIN;
                    end else if (word_count == LAST_ADDR) begin
                        // The overflowing word is still written, on the
                        // first ERR cycle, just like any other handshake.
                        state_nx = S_ERR;
                    end
                end
            end
            S_DRAIN: state_nx = S_RUN;
            S_RUN: begin
                // halted takes priority over a simultaneous timeout.
                if (halted) begin
                    state_nx = S_DONE;
                end else if (timeout_hit) begin
                    state_nx = S_TIMEOUT;
                end
            end
            S_DONE, S_TIMEOUT, S_ERR: begin
                if (start_load) begin
                    state_nx = S_LOAD;
                end
            end
            default: state_nx = S_LOAD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            run_cycles <= '0;
        end else begin
            state   <= state_nx;
            imem_we <= handshake;

            if (handshake) begin
                imem_waddr <= word_count[ADDR_W-1:0];
                imem_wdata <= ld_data;
                word_count <= word_count + 1'b1;
            end

            if ((state == S_RUN) && (run_cycles != 16'hFFFF)) begin
                run_cycles <= run_cycles + 16'd1;
            end

            if (terminal && start_load) begin
                word_count <= '0;
                run_cycles <= '0;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Instance u_a uses the default
// geometry (ADDR_W=8, TIMEOUT_CYCLES=200) and is driven mostly from a table
// of per-cycle vectors; instance u_b uses ADDR_W=2 for the overflow cases.
// Inputs change 1 ns after a rising edge and outputs are sampled at that
// same point, so each vector row shows the effect of one clock edge.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (ADDR_W=8) ----------------
    logic        a_reset, a_valid, a_last, a_start, a_halted;
    logic [15:0] a_data;
    logic        a_ready, a_we, a_cpu_reset, a_done, a_timeout, a_err;
    logic [7:0]  a_waddr;
    logic [15:0] a_wdata, a_rc;
    logic [8:0]  a_wc;

    imem_loader #(.ADDR_W(8), .TIMEOUT_CYCLES(200)) u_a (
        .clk(clk), .reset(a_reset), .ld_valid(a_valid), .ld_data(a_data),
        .ld_last(a_last), .ld_ready(a_ready), .start_load(a_start),
        .halted(a_halted), .imem_we(a_we), .imem_waddr(a_waddr),
        .imem_wdata(a_wdata), .cpu_reset(a_cpu_reset), .run_done(a_done),
        .run_timeout(a_timeout), .load_err(a_err), .word_count(a_wc),
        .run_cycles(a_rc)
    );

    // ---------------- instance B (ADDR_W=2) ----------------
    logic        b_reset, b_valid, b_last, b_start, b_halted;
    logic [15:0] b_data;
    logic        b_ready, b_we, b_cpu_reset, b_done, b_timeout, b_err;
    logic [1:0]  b_waddr;
    logic [15:0] b_wdata, b_rc;
    logic [2:0]  b_wc;

    imem_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(20)) u_b (
        .clk(clk), .reset(b_reset), .ld_valid(b_valid), .ld_data(b_data),
        .ld_last(b_last), .ld_ready(b_ready), .start_load(b_start),
        .halted(b_halted), .imem_we(b_we), .imem_waddr(b_waddr),
        .imem_wdata(b_wdata), .cpu_reset(b_cpu_reset), .run_done(b_done),
        .run_timeout(b_timeout), .load_err(b_err), .word_count(b_wc),
        .run_cycles(b_rc)
    );

    // Memory model and write-pulse counter for instance A.
    logic [15:0] mem_a [256];
    int          a_we_pulses = 0;
    always @(posedge clk) begin
        if (a_we) begin
            mem_a[a_waddr] <= a_wdata;
            a_we_pulses    <= a_we_pulses + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        last;
        logic        start;
        logic        halt;
        logic        we;
        logic [7:0]  waddr;
        logic [15:0] wdata;
        logic        ready;
        logic        crst;
        logic        done;
        logic [8:0]  wc;
        logic [15:0] rc;
    } vec_t;

    vec_t vecs[$];

    function automatic void push_vec(
        input logic valid, input logic [15:0] data, input logic last,
        input logic start, input logic halt,
        input logic we, input logic [7:0] waddr, input logic [15:0] wdata,
        input logic ready, input logic crst, input logic done,
        input logic [8:0] wc, input logic [15:0] rc);
        vec_t v;
        v.valid = valid; v.data = data; v.last = last; v.start = start;
        v.halt = halt; v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.ready = ready; v.crst = crst; v.done = done; v.wc = wc; v.rc = rc;
        vecs.push_back(v);
    endfunction

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            a_valid  = vecs[i].valid;
            a_data   = vecs[i].data;
            a_last   = vecs[i].last;
            a_start  = vecs[i].start;
            a_halted = vecs[i].halt;
            step();
            check($sformatf("v%0d.we", i), a_we, vecs[i].we);
            if (vecs[i].we) begin
                check($sformatf("v%0d.waddr", i), a_waddr, vecs[i].waddr);
                check($sformatf("v%0d.wdata", i), a_wdata, vecs[i].wdata);
            end
            check($sformatf("v%0d.ready", i), a_ready, vecs[i].ready);
            check($sformatf("v%0d.cpu_reset", i), a_cpu_reset, vecs[i].crst);
            check($sformatf("v%0d.done", i), a_done, vecs[i].done);
            check($sformatf("v%0d.timeout", i), a_timeout, 1'b0);
            check($sformatf("v%0d.err", i), a_err, 1'b0);
            check($sformatf("v%0d.wc", i), a_wc, vecs[i].wc);
            check($sformatf("v%0d.rc", i), a_rc, vecs[i].rc);
        end
        a_valid = 1'b0; a_last = 1'b0; a_start = 1'b0; a_halted = 1'b0;
    endtask

    // Push one loaded word then step; used by the hand-written sequences.
    task automatic a_word(input logic [15:0] d, input logic l);
        a_valid = 1'b1; a_data = d; a_last = l;
        step();
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic b_word(input logic [15:0] d, input logic l);
        b_valid = 1'b1; b_data = d; b_last = l;
        step();
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    logic [15:0] prog [5];
    int seg_a, seg_b, seg_c;
    int pulses0;
    int run_cnt;
    logic seen;

    initial begin
        prog[0] = 16'h4050; prog[1] = 16'h4081; prog[2] = 16'h129C;
        prog[3] = 16'h12A5; prog[4] = 16'hF000;

        // ---- segment A: back-to-back load, run, halt ----
        for (int k = 0; k < 5; k++)
            push_vec(1'b1, prog[k], k == 4, k == 2, 1'b0,
                     1'b1, 8'(k), prog[k], k < 4, 1'b1, 1'b0, 9'(k + 1), 16'd0);
        push_vec(0, 16'h0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 9'd5, 16'd0); // RUN entered
        push_vec(0, 16'h0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 9'd5, 16'd1); // start ignored
        push_vec(0, 16'h0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 9'd5, 16'd2);
        push_vec(0, 16'h0, 0, 0, 1,  0, 0, 0,  0, 1, 1, 9'd5, 16'd3); // halted
        push_vec(0, 16'h0, 0, 0, 0,  0, 0, 0,  0, 1, 1, 9'd5, 16'd3); // DONE holds
        seg_a = vecs.size();

        // ---- segment B: same program, ld_valid every other cycle ----
        push_vec(0, 16'h0, 0, 1, 0,  0, 0, 0,  1, 1, 0, 9'd0, 16'd0); // start_load
        for (int k = 0; k < 5; k++) begin
            push_vec(1'b1, prog[k], k == 4, 1'b0, 1'b0,
                     1'b1, 8'(k), prog[k], k < 4, 1'b1, 1'b0, 9'(k + 1), 16'd0);
            if (k < 4)
                push_vec(1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0,
                         1'b0, 8'd0, 16'd0, 1'b1, 1'b1, 1'b0, 9'(k + 1), 16'd0);
        end
        push_vec(0, 16'h0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 9'd5, 16'd0);
        push_vec(0, 16'h0, 0, 0, 1,  0, 0, 0,  0, 1, 1, 9'd5, 16'd1);
        seg_b = vecs.size();

        // ---- segment C: restart with a two-word program ----
        push_vec(0, 16'h0,    0, 1, 0,  0, 0, 0,        1, 1, 0, 9'd0, 16'd0);
        push_vec(1, 16'h4050, 0, 0, 0,  1, 0, 16'h4050, 1, 1, 0, 9'd1, 16'd0);
        push_vec(1, 16'hF000, 1, 0, 0,  1, 1, 16'hF000, 0, 1, 0, 9'd2, 16'd0);
        push_vec(0, 16'h0,    0, 0, 0,  0, 0, 0,        0, 0, 0, 9'd2, 16'd0);
        push_vec(0, 16'h0,    0, 0, 1,  0, 0, 0,        0, 1, 1, 9'd2, 16'd1);
        seg_c = vecs.size();

        a_reset = 1'b1; a_valid = 0; a_data = 0; a_last = 0; a_start = 0; a_halted = 0;
        b_reset = 1'b1; b_valid = 0; b_data = 0; b_last = 0; b_start = 0; b_halted = 0;
        step();
        step();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state (outputs right after the reset edges).
        check("rst.cpu_reset", a_cpu_reset, 1'b1);
        check("rst.ready", a_ready, 1'b1);
        check("rst.we", a_we, 1'b0);
        check("rst.waddr", a_waddr, 8'd0);
        check("rst.wdata", a_wdata, 16'd0);
        check("rst.wc", a_wc, 9'd0);
        check("rst.rc", a_rc, 16'd0);
        check("rst.flags", {a_done, a_timeout, a_err}, 3'b000);

        run_vecs(0, seg_a);
        for (int k = 0; k < 5; k++)
            check($sformatf("memA[%0d]", k), mem_a[k], prog[k]);

        pulses0 = a_we_pulses;
        run_vecs(seg_a, seg_b);
        check("toggle.we_pulses", a_we_pulses - pulses0, 5);
        for (int k = 0; k < 5; k++)
            check($sformatf("memB[%0d]", k), mem_a[k], prog[k]);

        run_vecs(seg_b, seg_c);
        check("prog2.mem1", mem_a[1], 16'hF000);

        // ---- timeout: program without HALT ----
        a_start = 1'b1; step(); a_start = 1'b0;
        a_word(16'h4050, 1'b0);
        a_word(16'h0000, 1'b0);
        a_word(16'h0000, 1'b1);
        run_cnt = 0;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            step();
            if (!a_cpu_reset) run_cnt++;
            if (a_timeout) seen = 1'b1;
        end
        check("to.seen", seen, 1'b1);
        check("to.run_cycles", a_rc, 16'd200);
        check("to.run_cnt", run_cnt, 200);
        check("to.cpu_reset", a_cpu_reset, 1'b1);
        check("to.done", a_done, 1'b0);
        check("to.wc", a_wc, 9'd3);
        step();
        check("to.hold", {a_timeout, a_rc}, {1'b1, 16'd200});

        // ---- halted on the same cycle as the timeout: DONE wins ----
        a_start = 1'b1; step(); a_start = 1'b0;
        check("to.clear", {a_timeout, a_rc, a_wc}, {1'b0, 16'd0, 9'd0});
        a_word(16'hF000, 1'b1);
        step();
        for (int n = 0; n < 300 && a_rc != 16'd199; n++) step();
        check("tie.rc199", a_rc, 16'd199);
        a_halted = 1'b1; step(); a_halted = 1'b0;
        check("tie.done", a_done, 1'b1);
        check("tie.timeout", a_timeout, 1'b0);
        check("tie.rc", a_rc, 16'd200);

        // ---- reset in the middle of RUN ----
        a_start = 1'b1; step(); a_start = 1'b0;
        a_word(16'h4050, 1'b0);
        a_word(16'h0000, 1'b1);
        step(); step(); step();
        check("mid.in_run", a_cpu_reset, 1'b0);
        a_reset = 1'b1; step(); a_reset = 1'b0;
        check("mid.cpu_reset", a_cpu_reset, 1'b1);
        check("mid.ready", a_ready, 1'b1);
        check("mid.rc", a_rc, 16'd0);
        check("mid.wc", a_wc, 9'd0);
        check("mid.we", a_we, 1'b0);
        check("mid.flags", {a_done, a_timeout, a_err}, 3'b000);

        // ---- ADDR_W=2 overflow ----
        for (int k = 0; k < 4; k++) b_word(16'h1000 + 16'(k), 1'b0);
        check("ovf.err", b_err, 1'b1);
        check("ovf.ready", b_ready, 1'b0);
        check("ovf.wc", b_wc, 3'd4);
        check("ovf.cpu_reset", b_cpu_reset, 1'b1);
        check("ovf.we", b_we, 1'b1);
        check("ovf.waddr", b_waddr, 2'd3);
        check("ovf.wdata", b_wdata, 16'h1003);
        b_word(16'h1004, 1'b1);
        check("ovf.5th_we", b_we, 1'b0);
        check("ovf.5th_state", {b_err, b_wc}, {1'b1, 3'd4});

        // ---- ADDR_W=2 with last on the 4th word: legal ----
        b_start = 1'b1; step(); b_start = 1'b0;
        check("full.clear", {b_err, b_ready, b_wc}, {1'b0, 1'b1, 3'd0});
        for (int k = 0; k < 4; k++) b_word(16'h2000 + 16'(k), k == 3);
        check("full.drain_we", {b_we, b_waddr}, {1'b1, 2'd3});
        check("full.drain_state", {b_err, b_ready, b_cpu_reset, b_wc}, {1'b0, 1'b0, 1'b1, 3'd4});
        step();
        check("full.run", b_cpu_reset, 1'b0);
        b_halted = 1'b1; step(); b_halted = 1'b0;
        check("full.done", {b_done, b_err, b_cpu_reset}, {1'b1, 1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
